// File: rtl/user_id_readout_pkg.sv
// user_id_readout_pkg: shared FSM states, register map and bit positions for the ID readout.
// USER_ID_PARITY_EN appends an even-parity bit to each serial frame.
package user_id_readout_pkg;
  typedef enum logic [1:0] {IDLE, SAMPLE, SHIFT} state_t;
  localparam logic [7:0] ID_OFS   = 8'h00;
  localparam logic [7:0] STAT_OFS = 8'h04;
  localparam int ST_LOCKED = 0;
  localparam int ST_BUSY   = 1;
  localparam int ST_ERR    = 2;
  localparam int ST_PARITY = 3;
  localparam int ST_MM_LSB = 8;
  localparam int CMD_CAPTURE = 0;
  localparam int CMD_SHIFT   = 1;
  localparam int CMD_CLR_ERR = 2;
`ifdef USER_ID_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif
  localparam logic [5:0] LAST_POS = PARITY_EN ? 6'd32 : 6'd31;
endpackage

// File: rtl/user_id_serializer.sv
// user_id_serializer: holds the ID shadow and streams it MSB-first over valid/ready.
// With USER_ID_PARITY_EN the frame carries a trailing even-parity bit.
module user_id_serializer
  import user_id_readout_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] load_data,
  input  logic        start,
  input  logic        sdo_ready,
  output logic [31:0] shadow,
  output logic        sdo_data,
  output logic        sdo_valid,
  output logic        sdo_last,
  output logic        done
);
  logic [5:0] pos;
  logic       bit_val;
  // pos counts bits sent; ~pos[4:0] maps it to the MSB-first shadow index
  always_comb begin
    bit_val   = pos[5] ? ^shadow : shadow[~pos[4:0]];
    sdo_data  = sdo_valid & bit_val;
    sdo_last  = sdo_valid & (pos == LAST_POS);
    done      = sdo_valid & sdo_ready & sdo_last;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      shadow    <= '0;
      pos       <= '0;
      sdo_valid <= 1'b0;
    end else begin
      if (load) shadow <= load_data;
      if (start) begin
        sdo_valid <= 1'b1;
        pos       <= '0;
      end else if (sdo_valid && sdo_ready) begin
        sdo_valid <= !sdo_last;
        pos       <= sdo_last ? 6'd0 : pos + 1'b1;
      end
    end
endmodule

// File: rtl/user_id_readout.sv
// user_id_readout: samples the hard-wired ID until stable, exposes it over Wishbone and a serial port.
// Define USER_ID_PARITY_EN to add a parity bit to the serial frame (reported in STATUS[3]).
module user_id_readout
  import user_id_readout_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int          SAMPLE_CNT = 4,
  parameter int          MISMATCH_W = 8
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [31:0] mask_rev,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_ack_o,
  output logic        sdo_data,
  output logic        sdo_valid,
  input  logic        sdo_ready,
  output logic        sdo_last
);
  state_t                state;
  logic                  locked, err, have;
  logic [3:0]            cnt;
  logic [31:0]           prev, shadow, status, rdata;
  logic [MISMATCH_W-1:0] mismatch;
  logic                  req, new_req, wr_stat, cap, shf, clr, busy;
  logic                  start, err_set, same, lock_now, done;
  always_comb begin
    req      = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    new_req  = req & !wbs_ack_o;
    wr_stat  = new_req & wbs_we_i & (wbs_adr_i[7:0] == STAT_OFS);
    cap      = wr_stat & wbs_dat_i[CMD_CAPTURE];
    shf      = wr_stat & wbs_dat_i[CMD_SHIFT];
    clr      = wr_stat & wbs_dat_i[CMD_CLR_ERR];
    busy     = state != IDLE;
    start    = shf & !cap & !busy & locked;
    // capture beats shift; shift needs a lock; nothing is accepted while busy
    err_set  = busy ? (cap | shf) : (shf & (cap | !locked));
    same     = have & (mask_rev == prev);
    lock_now = (state == SAMPLE) & same & (cnt == 4'(SAMPLE_CNT - 1));
    status   = '0;
    status[ST_LOCKED] = locked;
    status[ST_BUSY]   = busy;
    status[ST_ERR]    = err;
    status[ST_PARITY] = PARITY_EN;
    status[ST_MM_LSB +: 8] = 8'(mismatch);
    rdata    = (wbs_adr_i[7:0] == ID_OFS) ? shadow : (wbs_adr_i[7:0] == STAT_OFS) ? status : '0;
  end
  always_ff @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i) begin
      state     <= SAMPLE;
      locked    <= 1'b0;
      err       <= 1'b0;
      have      <= 1'b0;
      cnt       <= '0;
      prev      <= '0;
      mismatch  <= '0;
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      wbs_ack_o <= new_req;
      wbs_dat_o <= (new_req && !wbs_we_i) ? rdata : '0;
      err       <= err_set | (err & !clr);
      case (state)
        IDLE:
          if (cap) begin
            state  <= SAMPLE;
            locked <= 1'b0;
            have   <= 1'b0;
            cnt    <= '0;
          end else if (start) state <= SHIFT;
        SAMPLE: begin
          // the first sample after entry only seeds prev, so it never counts as a mismatch
          have <= 1'b1;
          prev <= mask_rev;
          if (lock_now) begin
            state  <= IDLE;
            locked <= 1'b1;
            cnt    <= '0;
          end else if (same) cnt <= cnt + 1'b1;
          else if (have) begin
            cnt      <= '0;
            mismatch <= (&mismatch) ? mismatch : mismatch + 1'b1;
          end
        end
        SHIFT: if (done) state <= IDLE;
        default: state <= SAMPLE;
      endcase
    end
  user_id_serializer u_ser (
    .clk       (wb_clk_i),
    .rst       (wb_rst_i),
    .load      (lock_now),
    .load_data (mask_rev),
    .start     (start),
    .sdo_ready (sdo_ready),
    .shadow    (shadow),
    .sdo_data  (sdo_data),
    .sdo_valid (sdo_valid),
    .sdo_last  (sdo_last),
    .done      (done)
  );
endmodule

// File: tb/tb_user_id_readout.sv
// tb_user_id_readout: directed bench for user_id_readout (default build and USER_ID_PARITY_EN).
module tb_user_id_readout;
  localparam logic [31:0] ID_A = 32'h3000_0000;
  localparam logic [31:0] ST_A = 32'h3000_0004;
`ifdef USER_ID_PARITY_EN
  localparam int   FL  = 33;
  localparam logic PAR = 1'b1;
`else
  localparam int   FL  = 32;
  localparam logic PAR = 1'b0;
`endif
  logic        clk = 0, rst = 1;
  logic [31:0] mask_rev = 32'hA5C3_0F17;
  logic        cyc = 0, stb = 0, we = 0, sdo_ready = 0;
  logic [31:0] adr = 0, dat_i = 0, dat_o;
  logic        ack, sdo_data, sdo_valid, sdo_last;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  user_id_readout dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .mask_rev(mask_rev),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_adr_i(adr), .wbs_dat_i(dat_i),
    .wbs_dat_o(dat_o), .wbs_ack_o(ack),
    .sdo_data(sdo_data), .sdo_valid(sdo_valid), .sdo_ready(sdo_ready), .sdo_last(sdo_last)
  );

  function automatic logic [32:0] expf(input logic [31:0] s);
    return (FL == 33) ? {s, ^s} : {1'b0, s};
  endfunction

  task automatic wb(input logic w, input logic [31:0] a, input logic [31:0] d,
                    output logic [31:0] r, output int lat);
    cyc = 1; stb = 1; we = w; adr = a; dat_i = d; lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!ack && lat < 8);
    r = ack ? dat_o : 32'hBAD0_0000;
    cyc = 0; stb = 0; we = 0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] r);
    int l;
    wb(1'b0, a, 32'h0, r, l);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] r;
    int l;
    wb(1'b1, a, d, r, l);
  endtask

  task automatic wait_lock;
    logic [31:0] r;
    for (int i = 0; i < 30; i++) begin
      rd(ST_A, r);
      if (r[0]) break;
    end
  endtask

  task automatic reset_read(input int n, input logic [31:0] a, output logic [31:0] r, output int lat);
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    for (int i = 1; i < n; i++) begin @(posedge clk); #1; end
    wb(1'b0, a, 32'h0, r, lat);
  endtask

  task automatic run_frame(input bit tog, input int need, input logic [32:0] fin,
                           output logic [32:0] fo, output int hs, output int ncyc,
                           output int nlast, output int lastat, output int bad);
    logic pd, pl, st;
    fo = fin; hs = 0; ncyc = 0; nlast = 0; lastat = -1; bad = 0; st = 0; pd = 0; pl = 0;
    while (hs < need && ncyc < 100) begin
      sdo_ready = !tog || !ncyc[0];
      @(negedge clk);
      if (st && (sdo_valid !== 1'b1 || sdo_data !== pd || sdo_last !== pl)) bad++;
      if (sdo_valid && sdo_ready) begin
        fo = {fo[31:0], sdo_data};
        if (sdo_last) begin nlast++; lastat = hs; end
        hs++;
        st = 0;
      end else begin
        st = sdo_valid; pd = sdo_data; pl = sdo_last;
      end
      ncyc++;
      @(posedge clk); #1;
    end
    sdo_ready = 0;
  endtask

  task automatic test_reset;
    logic [31:0] r;
    int lat;
    @(posedge clk); #1;
    checks++;
    if ({ack, dat_o, sdo_valid, sdo_data, sdo_last} !== 36'h0) begin
      failures++; $display("FAIL reset_outputs got=%h exp=0", {ack, dat_o, sdo_valid, sdo_data, sdo_last});
    end
    reset_read(6, ID_A, r, lat);
    checks++;
    if (r !== 32'hA5C3_0F17 || lat != 1) begin
      failures++; $display("FAIL id_after_lock got=%h lat=%0d exp=a5c30f17 lat=1", r, lat);
    end
    @(posedge clk); #1;
    checks++;
    if (ack !== 1'b0) begin failures++; $display("FAIL ack_one_cycle got=%b exp=0", ack); end
    reset_read(5, ID_A, r, lat);
    checks++;
    if (r !== 32'h0) begin failures++; $display("FAIL id_before_lock got=%h exp=0", r); end
    reset_read(5, ST_A, r, lat);
    checks++;
    if (r[15:0] !== 16'h0002) begin failures++; $display("FAIL stat_before_lock got=%h exp=0002", r[15:0]); end
    reset_read(6, ST_A, r, lat);
    checks++;
    if (r[15:0] !== {12'h0, PAR, 3'b001}) begin
      failures++; $display("FAIL stat_at_lock got=%h exp=%h", r[15:0], {12'h0, PAR, 3'b001});
    end
  endtask

  task automatic test_wb_decode;
    logic [31:0] r;
    int lat, seen;
    cyc = 1; stb = 1; we = 0; adr = 32'h3000_0100; seen = 0;
    repeat (6) begin @(posedge clk); #1; if (ack) seen++; end
    cyc = 0; stb = 0;
    checks++;
    if (seen != 0) begin failures++; $display("FAIL nonhit_ack got=%0d exp=0", seen); end
    wb(1'b0, 32'h3000_0008, 32'h0, r, lat);
    checks++;
    if (r !== 32'h0 || lat != 1) begin failures++; $display("FAIL other_ofs got=%h lat=%0d exp=0 lat=1", r, lat); end
    wr(ID_A, 32'hFFFF_FFFF);
    wr(32'h3000_000C, 32'h7);
    rd(ID_A, r);
    checks++;
    if (r !== 32'hA5C3_0F17) begin failures++; $display("FAIL id_write_ignored got=%h exp=a5c30f17", r); end
    rd(ST_A, r);
    checks++;
    if (r[2:0] !== 3'b001) begin failures++; $display("FAIL stat_after_ignored got=%b exp=001", r[2:0]); end
  endtask

  task automatic test_saturate;
    logic [31:0] r;
    rst = 1; mask_rev = 32'h1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    for (int i = 0; i < 300; i++) begin
      mask_rev = i[0] ? 32'h1 : 32'h2;
      @(posedge clk); #1;
    end
    mask_rev = 32'h2;
    repeat (4) @(posedge clk);
    #1;
    rd(ST_A, r);
    checks++;
    if (r[15:8] !== 8'hFF || r[1:0] !== 2'b10) begin
      failures++; $display("FAIL mismatch_sat got=%h exp=ff/10", {r[15:8], 6'h0, r[1:0]});
    end
    rd(ID_A, r);
    checks++;
    if (r !== 32'h2) begin failures++; $display("FAIL id_after_hold got=%h exp=2", r); end
    rd(ST_A, r);
    checks++;
    if (r[15:8] !== 8'hFF || r[1:0] !== 2'b01) begin
      failures++; $display("FAIL sat_locked got=%h exp=ff/01", {r[15:8], 6'h0, r[1:0]});
    end
  endtask

  task automatic test_shift;
    logic [31:0] r;
    logic [32:0] f;
    int hs, nc, nl, la, bad;
    mask_rev = 32'h8000_0001;
    wr(ST_A, 32'h1);
    wait_lock;
    wr(ST_A, 32'h2);
    run_frame(1'b0, FL, 33'h0, f, hs, nc, nl, la, bad);
    checks++;
    if (f !== expf(32'h8000_0001) || hs != FL) begin
      failures++; $display("FAIL shift_bits got=%h hs=%0d exp=%h", f, hs, expf(32'h8000_0001));
    end
    checks++;
    if (nc != FL) begin failures++; $display("FAIL shift_consecutive got=%0d exp=%0d", nc, FL); end
    checks++;
    if (nl != 1 || la != FL - 1) begin failures++; $display("FAIL shift_last got=%0d@%0d exp=1@%0d", nl, la, FL - 1); end
    checks++;
    if (sdo_valid !== 1'b0) begin failures++; $display("FAIL valid_after_frame got=%b exp=0", sdo_valid); end
    rd(ST_A, r);
    checks++;
    if (r[1] !== 1'b0) begin failures++; $display("FAIL busy_after_frame got=%b exp=0", r[1]); end
  endtask

  task automatic test_shift_stall;
    logic [32:0] f;
    int hs, nc, nl, la, bad;
    wr(ST_A, 32'h2);
    run_frame(1'b1, FL, 33'h0, f, hs, nc, nl, la, bad);
    checks++;
    if (f !== expf(32'h8000_0001) || hs != FL) begin
      failures++; $display("FAIL stall_bits got=%h hs=%0d exp=%h", f, hs, expf(32'h8000_0001));
    end
    checks++;
    if (bad != 0 || nc != 2 * FL - 1) begin
      failures++; $display("FAIL stall_hold got=%0d cyc=%0d exp=0 cyc=%0d", bad, nc, 2 * FL - 1);
    end
    checks++;
    if (nl != 1 || la != FL - 1) begin failures++; $display("FAIL stall_last got=%0d@%0d exp=1@%0d", nl, la, FL - 1); end
  endtask

  task automatic test_errors;
    logic [31:0] r;
    logic [32:0] f, g;
    int hs, nc, nl, la, bad;
    wr(ST_A, 32'h3);
    rd(ST_A, r);
    checks++;
    if (r[2:0] !== 3'b110) begin failures++; $display("FAIL cap_and_shift got=%b exp=110", r[2:0]); end
    wait_lock;
    rd(ST_A, r);
    checks++;
    if (r[2:0] !== 3'b101) begin failures++; $display("FAIL err_sticky got=%b exp=101", r[2:0]); end
    wr(ST_A, 32'h4);
    rd(ST_A, r);
    checks++;
    if (r[2:0] !== 3'b001) begin failures++; $display("FAIL err_clear got=%b exp=001", r[2:0]); end
    wr(ST_A, 32'h2);
    run_frame(1'b0, 5, 33'h0, f, hs, nc, nl, la, bad);
    wr(ST_A, 32'h2);
    rd(ST_A, r);
    checks++;
    if (r[2:0] !== 3'b111 || sdo_valid !== 1'b1) begin
      failures++; $display("FAIL shift_while_busy got=%b v=%b exp=111 v=1", r[2:0], sdo_valid);
    end
    run_frame(1'b0, FL - 5, f, g, hs, nc, nl, la, bad);
    checks++;
    if (g !== expf(32'h8000_0001) || nl != 1) begin
      failures++; $display("FAIL frame_not_restarted got=%h exp=%h", g, expf(32'h8000_0001));
    end
    wr(ST_A, 32'h4);
    rd(ST_A, r);
    checks++;
    if (r[2:0] !== 3'b001) begin failures++; $display("FAIL err_clear2 got=%b exp=001", r[2:0]); end
  endtask

  task automatic test_parity;
    logic [31:0] r;
    logic [32:0] f;
    int hs, nc, nl, la, bad;
    mask_rev = 32'h0000_0007;
    wr(ST_A, 32'h1);
    wait_lock;
    wr(ST_A, 32'h2);
    run_frame(1'b0, FL, 33'h0, f, hs, nc, nl, la, bad);
    checks++;
    if (f !== expf(32'h7) || nl != 1 || la != FL - 1) begin
      failures++; $display("FAIL parity_frame got=%h last@%0d exp=%h last@%0d", f, la, expf(32'h7), FL - 1);
    end
    rd(ST_A, r);
    checks++;
    if (r[3] !== PAR) begin failures++; $display("FAIL parity_status got=%b exp=%b", r[3], PAR); end
  endtask

  task automatic test_async_reset;
    logic [31:0] r;
    logic [32:0] f;
    int hs, nc, nl, la, bad, seen;
    wr(ST_A, 32'h2);
    run_frame(1'b0, 10, 33'h0, f, hs, nc, nl, la, bad);
    cyc = 1; stb = 1; we = 0; adr = ST_A;
    @(posedge clk); #1;
    checks++;
    if (ack !== 1'b1 || sdo_valid !== 1'b1) begin
      failures++; $display("FAIL pre_reset got=ack%b v%b exp=ack1 v1", ack, sdo_valid);
    end
    #2 rst = 1;
    #1;
    checks++;
    if ({ack, sdo_valid, sdo_data, sdo_last, dat_o} !== 36'h0) begin
      failures++; $display("FAIL async_drop got=%h exp=0", {ack, sdo_valid, sdo_data, sdo_last, dat_o});
    end
    cyc = 0; stb = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    sdo_ready = 1; seen = 0;
    repeat (4) begin @(posedge clk); #1; if (sdo_valid) seen++; end
    rd(ST_A, r);
    checks++;
    if (r[1:0] !== 2'b10) begin failures++; $display("FAIL relock_edge5 got=%b exp=10", r[1:0]); end
    sdo_ready = 1;
    repeat (20) begin @(posedge clk); #1; if (sdo_valid) seen++; end
    checks++;
    if (seen != 0) begin failures++; $display("FAIL frame_resumed got=%0d exp=0", seen); end
    rd(ST_A, r);
    checks++;
    if (r[1:0] !== 2'b01) begin failures++; $display("FAIL relocked got=%b exp=01", r[1:0]); end
    sdo_ready = 0;
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_wb_decode;
    test_saturate;
    test_shift;
    test_shift_stall;
    test_errors;
    test_parity;
    test_async_reset;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
